// File: rtl/viterbi_pkg.sv
// Shared types and trellis helpers for the 8-state (K=4) hard-decision Viterbi datapath.
package viterbi_pkg;

    localparam int NUM_STATES   = 8;
    localparam int PM_W_DFLT    = 8;
    localparam int PM_INIT_DFLT = 16;

    typedef logic [1:0]                 bm_t;
    typedef logic [PM_W_DFLT-1:0]       pm_t;
    typedef pm_t [NUM_STATES-1:0]       pm_vec_t;

    // Butterfly wiring: state i is reached from states 2i and 2i+1 (mod 8).
    function automatic int pred0(input int i);
        return (2 * i) % NUM_STATES;
    endfunction

    function automatic int pred1(input int i);
        return (2 * i + 1) % NUM_STATES;
    endfunction

    function automatic int init_pm(input int i, input int pm_init);
        return (i == 0) ? 0 : pm_init;
    endfunction

    localparam pm_vec_t INIT_VEC = {{(NUM_STATES-1){pm_t'(PM_INIT_DFLT)}}, pm_t'(0)};

endpackage

// File: rtl/acs_pm_unit_if.sv
// Symbol-in / decision-out bundle of the ACS + path-metric stage.
interface acs_pm_unit_if
    import viterbi_pkg::*;
#(
    parameter int PM_W     = 8,
    parameter int TB_DEPTH = 64
);
    localparam int AW = $clog2(TB_DEPTH);

    logic                               in_valid;
    logic                               start;
    logic [4*NUM_STATES-1:0]            bm;
    logic                               out_valid;
    logic [NUM_STATES-1:0]              decision;
    logic [NUM_STATES-1:0][PM_W-1:0]    pm;
    logic [2:0]                         best_state;
    logic [AW-1:0]                      wr_addr;

    modport master (
        output in_valid, start, bm,
        input  out_valid, decision, pm, best_state, wr_addr
    );

    modport slave (
        input  in_valid, start, bm,
        output out_valid, decision, pm, best_state, wr_addr
    );

endinterface

// File: rtl/acs_cell.sv
// Combinational add-compare-select for one trellis state; ties resolve to path_0.
module acs_cell
    import viterbi_pkg::*;
#(
    parameter int PM_W = 8
) (
    input  logic [PM_W-1:0] pm0,
    input  logic [PM_W-1:0] pm1,
    input  bm_t             bm0,
    input  bm_t             bm1,
    output logic [PM_W:0]   sum,
    output logic            dec
);

    logic [PM_W:0] c0;
    logic [PM_W:0] c1;

    assign c0  = {1'b0, pm0} + {{(PM_W-1){1'b0}}, bm0};
    assign c1  = {1'b0, pm1} + {{(PM_W-1){1'b0}}, bm1};
    assign dec = (c1 < c0);
    assign sum = dec ? c1 : c0;

endmodule

// File: rtl/acs_pm_unit.sv
// 8-state ACS + path-metric register stage: normalizes metrics, picks the best state
// and stamps each decision column with its trace-back write address.
module acs_pm_unit
    import viterbi_pkg::*;
#(
    parameter int PM_W     = 8,
    parameter int TB_DEPTH = 64,
    parameter int PM_INIT  = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    acs_pm_unit_if.slave  bus
);

    localparam int AW = $clog2(TB_DEPTH);

    typedef logic [NUM_STATES-1:0][PM_W-1:0] pmv_t;

    localparam logic [PM_W:0] HALF = {2'b01, {(PM_W-1){1'b0}}};

    function automatic pmv_t build_init();
        pmv_t v;
        for (int i = 0; i < NUM_STATES; i++) v[i] = PM_W'(init_pm(i, PM_INIT));
        return v;
    endfunction

    localparam pmv_t PM_INIT_V = build_init();

    pmv_t                            pm_q;
    pmv_t                            pm_src;
    pmv_t                            pm_new;
    logic [NUM_STATES-1:0][PM_W:0]   sum;
    logic [NUM_STATES-1:0]           dec;
    logic                            all_hi;
    logic [2:0]                      best;
    logic [PM_W-1:0]                 min_v;
    logic [AW-1:0]                   sym_addr;
    logic [AW-1:0]                   nxt_addr;

    logic                            vld_q;
    logic [NUM_STATES-1:0]           dec_q;
    logic [2:0]                      best_q;
    logic [AW-1:0]                   addr_q;

    // A start coincident with a symbol restarts the trellis for that very symbol.
    assign pm_src = bus.start ? PM_INIT_V : pm_q;

    generate
        for (genvar i = 0; i < NUM_STATES; i++) begin : g_acs
            acs_cell #(.PM_W(PM_W)) u_acs (
                .pm0 (pm_src[pred0(i)]),
                .pm1 (pm_src[pred1(i)]),
                .bm0 (bm_t'(bus.bm[4*i +: 2])),
                .bm1 (bm_t'(bus.bm[4*i+2 +: 2])),
                .sum (sum[i]),
                .dec (dec[i])
            );
        end
    endgenerate

    // Only rebase once the whole metric set has crossed the half-range mark.
    always_comb begin
        all_hi = 1'b1;
        for (int i = 0; i < NUM_STATES; i++) begin
            if (sum[i] < HALF) all_hi = 1'b0;
        end
        for (int i = 0; i < NUM_STATES; i++) begin
            pm_new[i] = all_hi ? PM_W'(sum[i] - HALF) : PM_W'(sum[i]);
        end
    end

    always_comb begin
        best  = '0;
        min_v = pm_new[0];
        for (int i = 1; i < NUM_STATES; i++) begin
            if (pm_new[i] < min_v) begin
                min_v = pm_new[i];
                best  = 3'(i);
            end
        end
    end

    assign sym_addr = bus.start ? '0 : nxt_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pm_q     <= PM_INIT_V;
            vld_q    <= 1'b0;
            dec_q    <= '0;
            best_q   <= '0;
            addr_q   <= '0;
            nxt_addr <= '0;
        end else begin
            vld_q <= bus.in_valid;
            if (bus.in_valid) begin
                pm_q     <= pm_new;
                dec_q    <= dec;
                best_q   <= best;
                addr_q   <= sym_addr;
                nxt_addr <= sym_addr + AW'(1);
            end else if (bus.start) begin
                pm_q     <= PM_INIT_V;
                nxt_addr <= '0;
            end
        end
    end

    assign bus.out_valid  = vld_q;
    assign bus.decision   = dec_q;
    assign bus.pm         = pm_q;
    assign bus.best_state = best_q;
    assign bus.wr_addr    = addr_q;

endmodule

// File: tb/tb_acs_pm_unit.sv
// Bench for acs_pm_unit: integer trellis model checked every negedge, plus literal anchors.
module tb_acs_pm_unit;

    localparam int PM_W     = 8;
    localparam int TB_DEPTH = 64;
    localparam int PM_INIT  = 16;
    localparam int NS       = 8;
    localparam int HALF     = 1 << (PM_W - 1);

    logic clk = 1'b0;
    logic rst_n;

    acs_pm_unit_if #(.PM_W(PM_W), .TB_DEPTH(TB_DEPTH)) bus();

    acs_pm_unit #(.PM_W(PM_W), .TB_DEPTH(TB_DEPTH), .PM_INIT(PM_INIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // model state (registered metrics as plain integers) and pending/visible outputs
    int mpm[NS];
    int m_next_addr;
    int p_pm[NS];
    int p_vld, p_dec, p_best, p_addr;
    int e_pm[NS];
    int e_vld, e_dec, e_best, e_addr;

    logic [31:0] pat[6] = '{32'h1A629045, 32'h2058A164, 32'h9A016285,
                            32'h46120A98, 32'h08952A16, 32'h6A401852};

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic commit();
        for (int i = 0; i < NS; i++) e_pm[i] = p_pm[i];
        e_vld  = p_vld;
        e_dec  = p_dec;
        e_best = p_best;
        e_addr = p_addr;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            mpm[i]  = (i == 0) ? 0 : PM_INIT;
            p_pm[i] = mpm[i];
        end
        m_next_addr = 0;
        p_vld = 0; p_dec = 0; p_best = 0; p_addr = 0;
        commit();
    endtask

    task automatic model_step(input bit v, input bit s, input logic [31:0] b);
        int base[NS];
        int sel[NS];
        int c0, c1, d, bst;
        bit hi;
        p_vld = v;
        if (!v) begin
            if (s) begin
                for (int i = 0; i < NS; i++) mpm[i] = (i == 0) ? 0 : PM_INIT;
                m_next_addr = 0;
            end
            for (int i = 0; i < NS; i++) p_pm[i] = mpm[i];
            return;
        end
        for (int i = 0; i < NS; i++) base[i] = s ? ((i == 0) ? 0 : PM_INIT) : mpm[i];
        d  = 0;
        hi = 1'b1;
        for (int i = 0; i < NS; i++) begin
            c0 = base[(2*i) % NS]     + int'(b[4*i +: 2]);
            c1 = base[(2*i + 1) % NS] + int'(b[4*i+2 +: 2]);
            if (c1 < c0) begin
                sel[i] = c1;
                d |= (1 << i);
            end else begin
                sel[i] = c0;
            end
            if (sel[i] < HALF) hi = 1'b0;
        end
        if (hi) for (int i = 0; i < NS; i++) sel[i] -= HALF;
        bst = 0;
        for (int i = 1; i < NS; i++) if (sel[i] < sel[bst]) bst = i;
        p_addr      = s ? 0 : m_next_addr;
        m_next_addr = (p_addr + 1) % TB_DEPTH;
        for (int i = 0; i < NS; i++) begin
            mpm[i]  = sel[i];
            p_pm[i] = sel[i];
        end
        p_dec  = d;
        p_best = bst;
    endtask

    task automatic sym(input bit v, input bit s, input logic [31:0] b);
        bus.in_valid = v;
        bus.start    = s;
        bus.bm       = b;
        model_step(v, s, b);
        @(posedge clk);
        #1;
        commit();
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("out_valid",  64'(bus.out_valid),  64'(e_vld));
            cmp("decision",   64'(bus.decision),   64'(e_dec));
            cmp("best_state", 64'(bus.best_state), 64'(e_best));
            cmp("wr_addr",    64'(bus.wr_addr),    64'(e_addr));
            for (int i = 0; i < NS; i++) cmp("pm", 64'(bus.pm[i]), 64'(e_pm[i]));
        end
    end

    initial begin
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        bus.bm       = '0;
        model_reset();
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // reset then first symbol: path_0 cost 0, path_1 cost 2 everywhere
        sym(1'b1, 1'b1, 32'h88888888);
        cmp("t1_pm",    64'(bus.pm),       64'h1010100010101000);
        cmp("t1_dec",   64'(bus.decision), 64'h00);
        cmp("t1_best",  64'(bus.best_state), 64'd0);
        cmp("t1_addr",  64'(bus.wr_addr),  64'd0);
        cmp("t1_vld",   64'(bus.out_valid), 64'd1);

        // state 5 tie (16+1 vs 16+1), then path_1 strictly cheaper (16+2 vs 16+1)
        sym(1'b1, 1'b1, 32'h88588888);
        cmp("tie_dec",  64'(bus.decision), 64'h00);
        sym(1'b1, 1'b1, 32'h88688888);
        cmp("p1_dec",   64'(bus.decision), 64'h20);
        cmp("p1_pm5",   64'(bus.pm[5]),    64'd17);

        // 65 symbols with cost 3 on every branch: metrics climb by 3 and rebase past 128
        for (int k = 0; k < 65; k++) begin
            sym(1'b1, (k == 0), 32'hFFFFFFFF);
            if (k == 41) cmp("pre_norm_pm",  64'(bus.pm), 64'h7E7E7E7E7E7E7E7E);
            if (k == 42) cmp("post_norm_pm", 64'(bus.pm), 64'h0101010101010101);
            if (k == 63) cmp("wrap_last",    64'(bus.wr_addr), 64'd63);
            if (k == 64) cmp("wrap_zero",    64'(bus.wr_addr), 64'd0);
        end

        // mixed realistic costs continuing the same frame
        for (int k = 0; k < 48; k++) sym(1'b1, 1'b0, pat[k % 6]);

        // gaps: everything holds
        for (int k = 0; k < 3; k++) begin
            sym(1'b0, 1'b0, 32'h0);
            cmp("gap_vld",  64'(bus.out_valid), 64'd0);
            cmp("gap_addr", 64'(bus.wr_addr),   64'd48);
        end

        // start alone reloads metrics, then the next symbol opens at address 0
        sym(1'b0, 1'b1, 32'h0);
        cmp("st_pm",   64'(bus.pm),        64'h1010101010101000);
        cmp("st_vld",  64'(bus.out_valid), 64'd0);
        cmp("st_addr", 64'(bus.wr_addr),   64'd48);
        sym(1'b1, 1'b0, 32'h88888888);
        cmp("st1_addr", 64'(bus.wr_addr), 64'd0);
        cmp("st1_pm",   64'(bus.pm),      64'h1010100010101000);
        sym(1'b1, 1'b0, 32'h88888888);
        cmp("st2_addr", 64'(bus.wr_addr), 64'd1);

        // asynchronous reset mid-frame, between edges
        for (int k = 0; k < 3; k++) sym(1'b1, 1'b0, pat[k]);
        #3;
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        rst_n        = 1'b0;
        model_reset();
        #1;
        cmp("ar_pm",   64'(bus.pm),         64'h1010101010101000);
        cmp("ar_vld",  64'(bus.out_valid),  64'd0);
        cmp("ar_dec",  64'(bus.decision),   64'd0);
        cmp("ar_best", 64'(bus.best_state), 64'd0);
        cmp("ar_addr", 64'(bus.wr_addr),    64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        sym(1'b1, 1'b0, 32'h88888888);
        cmp("rel_addr", 64'(bus.wr_addr),   64'd0);
        cmp("rel_pm",   64'(bus.pm),        64'h1010100010101000);
        cmp("rel_vld",  64'(bus.out_valid), 64'd1);

        sym(1'b0, 1'b0, 32'h0);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
